// File: rtl/neuron_weight_loader.sv
// Byte-stream loader that assembles a packed signed weight vector plus bias for a neuron.
// Optional trailing checksum byte is enabled by defining NEURON_LOADER_CHECKSUM_EN.
module neuron_weight_loader #(
    parameter int N_WEIGHTS = 256,
    parameter int W_WIDTH   = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           s_valid,
    output logic                           s_ready,
    input  logic [W_WIDTH-1:0]             s_data,
    output logic [N_WEIGHTS*W_WIDTH-1:0]   weights_out,
    output logic [W_WIDTH-1:0]             bias_out,
    output logic                           out_valid,
    input  logic                           out_ack,
    output logic                           busy,
    output logic                           err
);

    localparam int CW = (N_WEIGHTS > 1) ? $clog2(N_WEIGHTS) : 1;

`ifdef NEURON_LOADER_CHECKSUM_EN
    typedef enum logic [1:0] {
        LOAD_W = 2'd0,
        LOAD_B = 2'd1,
        LOAD_C = 2'd2,
        HOLD   = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        LOAD_W = 2'd0,
        LOAD_B = 2'd1,
        HOLD   = 2'd3
    } state_t;
`endif

    state_t                         state_q, state_d;
    logic [CW-1:0]                  count_q, count_d;
    logic [N_WEIGHTS*W_WIDTH-1:0]   weights_q, weights_d;
    logic [W_WIDTH-1:0]             bias_q, bias_d;
    logic                           xfer;

`ifdef NEURON_LOADER_CHECKSUM_EN
    logic [W_WIDTH-1:0]             sum_q, sum_d;
    logic                           err_q, err_d;
`endif

    assign s_ready     = (state_q != HOLD);
    assign out_valid   = (state_q == HOLD);
    assign xfer        = s_valid && s_ready;
    assign weights_out = weights_q;
    assign bias_out    = bias_q;

`ifdef NEURON_LOADER_CHECKSUM_EN
    assign busy = ((state_q == LOAD_W) && (count_q != '0)) || (state_q == LOAD_B) || (state_q == LOAD_C);
    assign err  = err_q;
`else
    assign busy = ((state_q == LOAD_W) && (count_q != '0)) || (state_q == LOAD_B);
    assign err  = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        weights_d = weights_q;
        bias_d    = bias_q;
`ifdef NEURON_LOADER_CHECKSUM_EN
        sum_d     = sum_q;
        err_d     = err_q;
`endif
        case (state_q)
            LOAD_W: begin
                if (xfer) begin
                    // weight 0 occupies the MSBs of the packed vector
                    weights_d[(N_WEIGHTS - 1 - int'(count_q)) * W_WIDTH +: W_WIDTH] = s_data;
`ifdef NEURON_LOADER_CHECKSUM_EN
                    sum_d = sum_q + s_data;
`endif
                    if (count_q == CW'(N_WEIGHTS - 1)) begin
                        count_d = '0;
                        state_d = LOAD_B;
                    end else begin
                        count_d = count_q + CW'(1);
                    end
                end
            end
            LOAD_B: begin
                if (xfer) begin
                    bias_d = s_data;
`ifdef NEURON_LOADER_CHECKSUM_EN
                    sum_d   = sum_q + s_data;
                    state_d = LOAD_C;
`else
                    state_d = HOLD;
`endif
                end
            end
`ifdef NEURON_LOADER_CHECKSUM_EN
            LOAD_C: begin
                if (xfer) begin
                    err_d   = (sum_q != s_data);
                    state_d = HOLD;
                end
            end
`endif
            HOLD: begin
                if (out_ack) begin
                    state_d = LOAD_W;
`ifdef NEURON_LOADER_CHECKSUM_EN
                    sum_d = '0;
                    err_d = 1'b0;
`endif
                end
            end
            default: state_d = LOAD_W;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= LOAD_W;
            count_q   <= '0;
            weights_q <= '0;
            bias_q    <= '0;
`ifdef NEURON_LOADER_CHECKSUM_EN
            sum_q     <= '0;
            err_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            weights_q <= weights_d;
            bias_q    <= bias_d;
`ifdef NEURON_LOADER_CHECKSUM_EN
            sum_q     <= sum_d;
            err_q     <= err_d;
`endif
        end
    end

endmodule

// File: tb/tb_neuron_weight_loader.sv
// Scoreboard bench for neuron_weight_loader: a 4-weight instance and a 256-weight instance.
// Checksum scenarios run only when NEURON_LOADER_CHECKSUM_EN is defined.
module tb_neuron_weight_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // 4-weight instance
    logic         rst4_n, v4, r4, ov4, ack4, busy4, err4;
    logic [7:0]   d4, b4;
    logic [31:0]  w4;
    // 256-weight instance
    logic         rst8_n, v8, r8, ov8, ack8, busy8, err8;
    logic [7:0]   d8, b8;
    logic [2047:0] w8;

    neuron_weight_loader #(.N_WEIGHTS(4), .W_WIDTH(8)) u_dut4 (
        .clk(clk), .rst_n(rst4_n), .s_valid(v4), .s_ready(r4), .s_data(d4),
        .weights_out(w4), .bias_out(b4), .out_valid(ov4), .out_ack(ack4),
        .busy(busy4), .err(err4)
    );

    neuron_weight_loader #(.N_WEIGHTS(256), .W_WIDTH(8)) u_dut256 (
        .clk(clk), .rst_n(rst8_n), .s_valid(v8), .s_ready(r8), .s_data(d8),
        .weights_out(w8), .bias_out(b8), .out_valid(ov8), .out_ack(ack8),
        .busy(busy8), .err(err8)
    );

    typedef struct packed {
        logic [31:0] w;
        logic [7:0]  b;
        logic        e;
    } exp4_t;

    exp4_t        q4[$];
    logic [2047:0] qw8[$];
    logic [7:0]   qb8[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitors: compare the presented set each time out_valid rises.
    logic ov4_prev = 1'b0;
    always @(negedge clk) begin : mon4
        exp4_t e;
        if (ov4 && !ov4_prev) begin
            if (q4.size() == 0) begin
                total++;
                bad++;
                $display("FAIL set4 unexpected: out_valid rose with no set pending");
            end else begin
                e = q4.pop_front();
                chk("set4 weights", 64'(w4), 64'(e.w));
                chk("set4 bias", 64'(b4), 64'(e.b));
                chk("set4 err", 64'(err4), 64'(e.e));
            end
        end
        ov4_prev <= ov4;
    end

    logic ov8_prev = 1'b0;
    always @(negedge clk) begin : mon8
        logic [2047:0] ew;
        int first;
        if (ov8 && !ov8_prev) begin
            if (qw8.size() == 0 || qb8.size() == 0) begin
                total++;
                bad++;
                $display("FAIL set256 unexpected: out_valid rose with no set pending");
            end else begin
                ew = qw8.pop_front();
                first = -1;
                for (int k = 255; k >= 0; k--)
                    if (w8[2047 - k*8 -: 8] !== ew[2047 - k*8 -: 8]) first = k;
                total++;
                if (first >= 0) begin
                    bad++;
                    $display("FAIL set256 weights: weight %0d got %0h expected %0h",
                             first, w8[2047 - first*8 -: 8], ew[2047 - first*8 -: 8]);
                end
                chk("set256 bias", 64'(b8), 64'(qb8.pop_front()));
            end
        end
        ov8_prev <= ov8;
    end

    // Present a byte from the negedge; returns 1 time unit after the transferring posedge.
    task automatic send4(input logic [7:0] d);
        int n = 0;
        @(negedge clk);
        v4 = 1'b1;
        d4 = d;
        while (!r4 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            total++;
            bad++;
            $display("FAIL send4 timeout: s_ready=%0b required 1", r4);
        end
        @(posedge clk);
        #1 v4 = 1'b0;
    endtask

    task automatic send8(input logic [7:0] d);
        int n = 0;
        repeat ($urandom_range(0, 2)) @(negedge clk);
        @(negedge clk);
        v8 = 1'b1;
        d8 = d;
        while (!r8 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            total++;
            bad++;
            $display("FAIL send8 timeout: s_ready=%0b required 1", r8);
        end
        @(posedge clk);
        #1 v8 = 1'b0;
    endtask

    // Load a 4-weight set; skip_w0 when weight 0 was already handed over manually.
    task automatic load4(input logic [31:0] w, input logic [7:0] b, input bit skip_w0, input bit bad_cs);
        exp4_t e;
        logic [7:0] sum;
        sum = w[31:24] + w[23:16] + w[15:8] + w[7:0] + b;
        e.w = w;
        e.b = b;
`ifdef NEURON_LOADER_CHECKSUM_EN
        e.e = bad_cs;
`else
        e.e = 1'b0;
`endif
        q4.push_back(e);
        if (!skip_w0) send4(w[31:24]);
        send4(w[23:16]);
        send4(w[15:8]);
        send4(w[7:0]);
`ifdef NEURON_LOADER_CHECKSUM_EN
        send4(b);
        chk("out_valid before checksum byte", 64'(ov4), 64'd0);
        send4(bad_cs ? sum - 8'd1 : sum);
`else
        chk("out_valid before final byte", 64'(ov4), 64'd0);
        send4(b);
`endif
        chk("out_valid after final byte", 64'(ov4), 64'd1);
        chk("s_ready in HOLD", 64'(r4), 64'd0);
    endtask

    task automatic ack4_pulse();
        @(negedge clk);
        ack4 = 1'b1;
        @(posedge clk);
        #1 ack4 = 1'b0;
        chk("out_valid after ack", 64'(ov4), 64'd0);
        chk("s_ready after ack", 64'(r4), 64'd1);
        chk("err after ack", 64'(err4), 64'd0);
    endtask

    task automatic load8();
        logic [2047:0] ew;
        logic [7:0] sum = 8'd0;
        for (int k = 0; k < 256; k++) begin
            ew[2047 - k*8 -: 8] = k[7:0];
            sum = sum + k[7:0];
        end
        sum = sum + 8'h80;
        qw8.push_back(ew);
        qb8.push_back(8'h80);
        for (int k = 0; k < 256; k++) send8(k[7:0]);
        send8(8'h80);
`ifdef NEURON_LOADER_CHECKSUM_EN
        send8(sum);
`endif
        chk("set256 out_valid", 64'(ov8), 64'd1);
    endtask

    initial begin
        int n;
        rst4_n = 1'b0; rst8_n = 1'b0;
        v4 = 1'b0; d4 = '0; ack4 = 1'b0;
        v8 = 1'b0; d8 = '0; ack8 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst4_n = 1'b1; rst8_n = 1'b1;
        chk("reset weights", 64'(w4), 64'd0);
        chk("reset bias", 64'(b4), 64'd0);
        chk("reset out_valid", 64'(ov4), 64'd0);
        chk("reset busy", 64'(busy4), 64'd0);
        chk("reset err", 64'(err4), 64'd0);
        chk("reset s_ready", 64'(r4), 64'd1);

        // Basic load, then hold under backpressure
        load4(32'h01020304, 8'h7F, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("hold weights stable", 64'(w4), 64'h01020304);
            chk("hold bias stable", 64'(b4), 64'h7F);
            chk("hold s_ready", 64'(r4), 64'd0);
            chk("hold out_valid", 64'(ov4), 64'd1);
        end
        ack4_pulse();
        chk("weights kept after ack", 64'(w4), 64'h01020304);

        // First byte after ack lands in weight 0; the rest is left until overwritten
        q4.push_back('{w: 32'hAA112233, b: 8'h44, e: 1'b0});
        send4(8'hAA);
        chk("weight0 after ack", 64'(w4), 64'hAA020304);
        chk("busy after first weight", 64'(busy4), 64'd1);
        void'(q4.pop_back());
        load4(32'hAA112233, 8'h44, 1'b1, 1'b0);

        // Ack and s_valid together in HOLD
        @(negedge clk);
        ack4 = 1'b1;
        v4 = 1'b1;
        d4 = 8'h55;
        @(posedge clk);
        #1 ack4 = 1'b0;
        chk("simul ack: byte not taken", 64'(w4), 64'hAA112233);
        chk("simul ack: busy", 64'(busy4), 64'd0);
        chk("simul ack: out_valid", 64'(ov4), 64'd0);
        @(posedge clk);
        #1 v4 = 1'b0;
        chk("simul ack: weight0 next cycle", 64'(w4), 64'h55112233);
        chk("simul ack: busy count 1", 64'(busy4), 64'd1);
        load4(32'h55667788, 8'h99, 1'b1, 1'b0);
        ack4_pulse();

`ifdef NEURON_LOADER_CHECKSUM_EN
        load4(32'h01020304, 8'h05, 1'b0, 1'b0);
        chk("checksum good err", 64'(err4), 64'd0);
        ack4_pulse();
        load4(32'h01020304, 8'h05, 1'b0, 1'b1);
        chk("checksum bad err", 64'(err4), 64'd1);
        ack4_pulse();
`endif

        // Reset mid-load on the wide instance, then a full set with bubbles
        for (int k = 0; k < 100; k++) send8(8'hC3);
        chk("busy mid-load", 64'(busy8), 64'd1);
        @(negedge clk);
        rst8_n = 1'b0;
        @(posedge clk);
        #1 rst8_n = 1'b1;
        chk("mid reset weights zero", 64'(w8 == '0), 64'd1);
        chk("mid reset bias", 64'(b8), 64'd0);
        chk("mid reset out_valid", 64'(ov8), 64'd0);
        chk("mid reset busy", 64'(busy8), 64'd0);
        chk("mid reset err", 64'(err8), 64'd0);
        load8();

        n = 0;
        while ((q4.size() != 0 || qw8.size() != 0) && n < 50) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (q4.size() != 0 || qw8.size() != 0) begin
            bad++;
            $display("FAIL pending sets: got %0d/%0d still queued, required 0/0", q4.size(), qw8.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
